// File: rtl/mult_integrate_dump.sv
// Integrate-and-dump averager: sums blocks of N = 2^LOG_N signed samples framed by in_first
// and emits the rounded block mean; a marker arriving mid-block restarts the block and flags out_err.
module mult_integrate_dump #(
    parameter int WDTH  = 16,
    parameter int LOG_N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [WDTH-1:0] in_data,
    input  logic                   in_nd,
    input  logic                   in_first,
    output logic signed [WDTH-1:0] out_data,
    output logic                   out_nd,
    output logic                   out_err
);

    localparam int ACC_W = WDTH + LOG_N;
    localparam logic [LOG_N-1:0]        CNT_LAST = '1;
    localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1) << (LOG_N - 1);

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        ACCUM      = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [LOG_N-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WDTH-1:0]  out_data_q, out_data_d;
    logic                    out_nd_q, out_nd_d;
    logic                    out_err_q, out_err_d;

    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;

    assign in_ext = {{LOG_N{in_data[WDTH-1]}}, in_data};
    assign sum    = acc_q + in_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_FIRST;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_nd_q   <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_nd_q   <= out_nd_d;
            out_err_q  <= out_err_d;
        end
    end

    // Once synchronised the FSM never leaves ACCUM; only reset returns it to WAIT_FIRST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_FIRST: if (in_nd && in_first) state_d = ACCUM;
            ACCUM:      state_d = ACCUM;
            default:    state_d = WAIT_FIRST;
        endcase
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_nd_d   = 1'b0;
        out_err_d  = 1'b0;
        if (in_nd) begin
            if (in_first) begin
                acc_d     = in_ext;
                cnt_d     = LOG_N'(1);
                // cnt_q == 0 right after a dump, so a marker there is a clean block start
                out_err_d = (state_q == ACCUM) && (cnt_q != '0);
            end else if (state_q == ACCUM) begin
                if (cnt_q == CNT_LAST) begin
                    out_data_d = WDTH'((sum + HALF) >>> LOG_N);
                    out_nd_d   = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_data = out_data_q;
    assign out_nd   = out_nd_q;
    assign out_err  = out_err_q;

endmodule

// File: tb/tb_mult_integrate_dump.sv
// Bench for mult_integrate_dump (WDTH=16, LOG_N=2): block-list model plus per-cycle compare
// and literal expectations on the directed scenarios.
module tb_mult_integrate_dump;

    localparam int WDTH  = 16;
    localparam int LOG_N = 2;
    localparam int N     = 1 << LOG_N;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic signed [WDTH-1:0] in_data = '0;
    logic                   in_nd = 1'b0;
    logic                   in_first = 1'b0;
    logic signed [WDTH-1:0] out_data;
    logic                   out_nd;
    logic                   out_err;

    int nvec = 0;
    int nerr = 0;

    mult_integrate_dump #(.WDTH(WDTH), .LOG_N(LOG_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .in_first (in_first),
        .out_data (out_data),
        .out_nd   (out_nd),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    // Model: the samples of the current block as a list; mean by floor division.
    int blk[$];
    bit synced = 1'b0;
    int exp_data = 0;
    bit exp_nd = 1'b0;
    bit exp_err = 1'b0;

    function automatic int block_mean(input int s[$]);
        int sum, q;
        sum = 0;
        foreach (s[i]) sum += s[i];
        q = sum + N / 2;
        if (q >= 0) return q / N;
        return -((-q + N - 1) / N);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk.delete();
            synced   = 1'b0;
            exp_data = 0;
            exp_nd   = 1'b0;
            exp_err  = 1'b0;
        end else begin
            exp_nd  = 1'b0;
            exp_err = 1'b0;
            if (in_nd) begin
                if (in_first) begin
                    if (blk.size() > 0) exp_err = 1'b1;
                    blk.delete();
                    blk.push_back(int'(in_data));
                    synced = 1'b1;
                end else if (synced) begin
                    blk.push_back(int'(in_data));
                end
                if (blk.size() == N) begin
                    exp_data = block_mean(blk);
                    exp_nd   = 1'b1;
                    blk.delete();
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("out_nd", int'(out_nd), int'(exp_nd));
        check("out_err", int'(out_err), int'(exp_err));
        check("out_data", int'(out_data), exp_data);
    end

    task automatic smp(input int d, input bit first);
        @(negedge clk);
        #2;
        in_data  = WDTH'(d);
        in_nd    = 1'b1;
        in_first = first;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            in_nd    = 1'b0;
            in_first = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic dump_chk(input string nm, input int want);
        check({nm, "_nd"}, int'(out_nd), 1);
        check({nm, "_data"}, int'(out_data), want);
        check({nm, "_err"}, int'(out_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", int'(out_data), 0);
        check("rst_nd", int'(out_nd), 0);
        check("rst_err", int'(out_err), 0);
        #2 rst_n = 1'b1;

        // pre-sync samples dropped, gaps inside a block
        smp(5, 0); smp(6, 0);
        gap(1);
        check("presync_nd", int'(out_nd), 0);
        smp(8, 1); gap(3); smp(8, 0); gap(1); smp(8, 0); smp(8, 0);
        gap(1);
        dump_chk("gaps", 8);
        smp(4, 0); smp(4, 0); smp(4, 0); smp(4, 0);
        gap(1);
        dump_chk("nofirst", 4);
        gap(2);
        check("hold_data", int'(out_data), 4);

        smp(100, 1); smp(200, 0); smp(300, 0); smp(400, 0);
        gap(1);
        dump_chk("basic", 250);
        check("model_basic", exp_data, 250);

        smp(1, 1); smp(1, 0); smp(1, 0); smp(0, 0);
        gap(1);
        dump_chk("round_p3", 1);
        smp(-1, 1); smp(-1, 0); smp(-1, 0); smp(-2, 0);
        gap(1);
        dump_chk("round_m5", -1);
        check("model_m5", exp_data, -1);
        smp(2, 1); smp(0, 0); smp(0, 0); smp(0, 0);
        gap(1);
        dump_chk("round_p2", 1);

        for (int i = 0; i < 4; i++) smp(32767, i == 0);
        gap(1);
        dump_chk("max", 32767);
        for (int i = 0; i < 4; i++) smp(-32768, i == 0);
        gap(1);
        dump_chk("min", -32768);
        check("model_min", exp_data, -32768);

        // mid-block marker restarts the block
        smp(10, 1); smp(20, 0); smp(30, 1); smp(30, 0);
        check("resync_err", int'(out_err), 1);
        check("resync_nd", int'(out_nd), 0);
        smp(30, 0); smp(30, 0);
        gap(1);
        dump_chk("resync", 30);

        // reset mid-block drops the partial sum and forces resync
        smp(100, 1); smp(100, 0);
        @(negedge clk);
        #2;
        in_nd = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_data", int'(out_data), 0);
        check("midrst_nd", int'(out_nd), 0);
        check("midrst_err", int'(out_err), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) smp(7, 0);
        gap(1);
        check("postrst_nd", int'(out_nd), 0);
        for (int i = 0; i < 4; i++) smp(9, i == 0);
        gap(1);
        dump_chk("postrst", 9);
        gap(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
